uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial input and byte-side outputs of the 8N1 receiver.
// The receiver drives the byte side; the line owner drives rx.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rxbyte;
    logic       rxdone;
    logic       rxerr;
    logic       busy;

    modport master (
        input  rx,
        output rxbyte,
        output rxdone,
        output rxerr,
        output busy
    );

    modport slave (
        output rx,
        input  rxbyte,
        input  rxdone,
        input  rxerr,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error
// strobe and break recovery.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      resetn,
    uart_rx_if.master bus
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(H - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_n;
    logic          s1, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    rxbyte_q, byte_n;
    logic          done_q, done_n;
    logic          err_q, err_n;

    // rx is asynchronous: only the second flop is ever used
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            s1   <= bus.rx;
            rx_s <= s1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            rxbyte_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            rxbyte_q <= byte_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        byte_n  = rxbyte_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    // a start bit gone high by mid-bit is a glitch
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        byte_n  = shreg;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rxbyte = rxbyte_q;
    assign bus.rxdone = done_q;
    assign bus.rxerr  = err_q;
    assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed frames for uart_rx with a queue-based scoreboard
// checking strobe kind, byte value and strobe cycle.
module tb_uart_rx;

    localparam int CPB = 16;

    typedef struct {
        logic       err;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic clk;
    logic resetn;
    int   cyc;
    int   total;
    int   bad;
    logic [7:0] last_good;
    logic       prev_strobe;
    exp_t       exp_q[$];

    uart_rx_if u_if ();

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int got,
                       input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, got, exp);
        end
    endtask

    // monitor: pops one expectation per strobe
    always @(negedge clk) begin
        if (resetn && (u_if.rxdone || u_if.rxerr)) begin
            exp_t e;
            chk("strobe_width", int'(prev_strobe), 0);
            chk("done_and_err",
                int'(u_if.rxdone && u_if.rxerr), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe done=%0b err=%0b",
                         u_if.rxdone, u_if.rxerr);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", int'(u_if.rxerr), int'(e.err));
                chk("rxbyte", int'(u_if.rxbyte), int'(e.b));
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
        prev_strobe = resetn && (u_if.rxdone || u_if.rxerr);
    end

    task automatic line_bit(input logic v);
        u_if.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // called at a negedge; stop_ok=0 holds line low afterwards
    task automatic send(input logic [7:0] b,
                        input logic stop_ok,
                        input int hold_bits);
        exp_t e;
        e.err = !stop_ok;
        e.b   = stop_ok ? b : last_good;
        e.cyc = cyc + 1 + 154;
        exp_q.push_back(e);
        if (stop_ok) last_good = b;
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop_ok);
        for (int i = 0; i < hold_bits; i++) line_bit(1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int e0;
        total       = 0;
        bad         = 0;
        last_good   = 8'h00;
        prev_strobe = 1'b0;
        resetn      = 1'b0;
        u_if.rx     = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            u_if.rx = i[0];
        end
        chk("rst_rxbyte", int'(u_if.rxbyte), 8'h00);
        chk("rst_rxdone", int'(u_if.rxdone), 0);
        chk("rst_rxerr", int'(u_if.rxerr), 0);
        chk("rst_busy", int'(u_if.busy), 0);
        u_if.rx = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", int'(u_if.busy), 0);

        send(8'hA5, 1'b1, 0);
        drain();
        repeat (20) @(negedge clk);

        send(8'h00, 1'b1, 0);
        send(8'hFF, 1'b1, 0);
        drain();
        repeat (20) @(negedge clk);

        // glitch: 4 low cycles
        e0 = cyc + 1;
        u_if.rx = 1'b0;
        repeat (4) @(negedge clk);
        u_if.rx = 1'b1;
        while (cyc != e0 + 9) @(negedge clk);
        chk("glitch_busy_hi", int'(u_if.busy), 1);
        @(negedge clk);
        chk("glitch_busy_lo", int'(u_if.busy), 0);
        repeat (40) @(negedge clk);
        chk("glitch_rxbyte", int'(u_if.rxbyte), 8'hFF);

        send(8'h3C, 1'b1, 0);
        drain();
        repeat (10) @(negedge clk);
        send(8'h3C, 1'b0, 3);
        drain();
        chk("break_busy", int'(u_if.busy), 1);
        chk("break_rxbyte", int'(u_if.rxbyte), 8'h3C);
        u_if.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("break_exit_busy", int'(u_if.busy), 0);
        repeat (20) @(negedge clk);
        send(8'h81, 1'b1, 0);
        drain();
        repeat (20) @(negedge clk);

        // reset during data bit 4
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(i[0]);
        u_if.rx = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy_pre", int'(u_if.busy), 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_rxbyte", int'(u_if.rxbyte), 8'h00);
        chk("mid_rst_busy", int'(u_if.busy), 0);
        chk("mid_rst_done", int'(u_if.rxdone), 0);
        u_if.rx = 1'b1;
        last_good = 8'h00;
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_post_busy", int'(u_if.busy), 0);
        send(8'h12, 1'b1, 0);
        drain();
        repeat (40) @(negedge clk);
        chk("final_rxbyte", int'(u_if.rxbyte), 8'h12);
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
